// File: rtl/wb_irq_ctrl.sv
// Wishbone B3 slave interrupt controller: per-source synchroniser, polarity, edge/level mode, mask, W1C pending.
// Define WB_IRQ_CTRL_PRIO_EN to add the read-only PRIO register at 0x14 (lowest pending+masked source).
module wb_irq_ctrl #(
   parameter int          NUM_SRC     = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RESET_MASK  = 32'h0
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic [4:0]         wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   input  logic [3:0]         wb_sel_i,
   input  logic               wb_we_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic [2:0]         wb_cti_i,
   input  logic [1:0]         wb_bte_i,
   output logic [31:0]        wb_dat_o,
   output logic               wb_ack_o,
   output logic               wb_err_o,
   input  logic [NUM_SRC-1:0] irq_i,
   output logic [NUM_SRC-1:0] irq_o
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t             state_q;
   logic               ack_q, err_q;
   logic [31:0]        dat_q;
   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, pol_q, pol_d, s_d_q, s_d_d;
   logic [NUM_SRC-1:0] s_cur, rise, clr, chg, wdat, wbe, irq_act;
   logic [31:0]        be32, rd_data;
   logic [2:0]         reg_sel;
   logic               acc, wr_acc, mapped;
   logic               unused_ok;

   assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i, be32};

   assign reg_sel = wb_adr_i[4:2];
   assign acc     = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
   assign wr_acc  = acc && wb_we_i;
   assign be32    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign wdat    = wb_dat_i[NUM_SRC-1:0];
   assign wbe     = be32[NUM_SRC-1:0];
   assign irq_act = pend_q & mask_q;
   assign irq_o   = irq_act;

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= irq_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      mask_d = mask_q;
      mode_d = mode_q;
      pol_d  = pol_q;
      clr    = '0;
      if (wr_acc) begin
         case (reg_sel)
            3'd1:    clr    = wdat & wbe;
            3'd2:    mask_d = (mask_q & ~wbe) | (wdat & wbe);
            3'd3:    mode_d = (mode_q & ~wbe) | (wdat & wbe);
            3'd4:    pol_d  = (pol_q  & ~wbe) | (wdat & wbe);
            default: ;
         endcase
      end
      // Reconfigured bits restart clean: pending dropped, edge history reloaded with the new polarity.
      chg    = (mode_d ^ mode_q) | (pol_d ^ pol_q);
      s_cur  = sync_q[SYNC_STAGES-1] ^ pol_q;
      rise   = s_cur & ~s_d_q;
      pend_d = ~chg & ((mode_d & ((pend_q & ~clr) | rise)) | (~mode_d & s_cur));
      s_d_d  = sync_q[SYNC_STAGES-1] ^ pol_d;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         pend_q <= '0;
         mask_q <= RESET_MASK[NUM_SRC-1:0];
         mode_q <= '0;
         pol_q  <= '0;
         s_d_q  <= '0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
         pol_q  <= pol_d;
         s_d_q  <= s_d_d;
      end
   end

`ifdef WB_IRQ_CTRL_PRIO_EN
   logic [31:0] prio;
   always_comb begin
      prio = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (irq_act[i]) prio = {1'b1, 26'b0, 5'(i)};
   end
`endif

   always_comb begin
      mapped  = 1'b1;
      rd_data = '0;
      case (reg_sel)
         3'd0:    rd_data = 32'(irq_act);
         3'd1:    rd_data = 32'(pend_q);
         3'd2:    rd_data = 32'(mask_q);
         3'd3:    rd_data = 32'(mode_q);
         3'd4:    rd_data = 32'(pol_q);
`ifdef WB_IRQ_CTRL_PRIO_EN
         3'd5:    rd_data = prio;
`endif
         default: mapped = 1'b0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  state_q <= ACK;
                  ack_q   <= mapped;
                  err_q   <= !mapped;
                  dat_q   <= rd_data;
               end
            end
            ACK: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl: bus responses checked by a scoreboard monitor, irq_o timing checked inline.
module tb_wb_irq_ctrl;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    adr = '0;
   logic [31:0]   wdat = '0;
   logic [3:0]    sel = '0;
   logic          we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic [2:0]    cti = '0;
   logic [1:0]    bte = '0;
   logic [31:0]   dat_o;
   logic          ack_o, err_o;
   logic [N-1:0]  irq_i = '0;
   logic [N-1:0]  irq_o;

   typedef struct {
      logic        err;
      logic        chk_dat;
      logic [31:0] dat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   wb_irq_ctrl dut (
      .wb_clk_i (clk),   .wb_rst_ni(rst_n), .wb_adr_i(adr),  .wb_dat_i(wdat),
      .wb_sel_i (sel),   .wb_we_i  (we),    .wb_cyc_i(cyc),  .wb_stb_i(stb),
      .wb_cti_i (cti),   .wb_bte_i (bte),   .wb_dat_o(dat_o), .wb_ack_o(ack_o),
      .wb_err_o (err_o), .irq_i    (irq_i), .irq_o   (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (ack_o || err_o)) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: ack=%0b err=%0b, required no response", ack_o, err_o);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_ackerr"}, {30'b0, ack_o, err_o}, {30'b0, !e.err, e.err});
            if (e.chk_dat) chk({e.name, "_dat"}, dat_o, e.dat);
         end
      end
   end

   task automatic cyc_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives from the current time, waits for ack/err, then releases the bus.
   task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic exp_err, input logic [31:0] exp_dat, input string name);
      exp_t e;
      int   n;
      e.err = exp_err;
      e.chk_dat = !w;
      e.dat = exp_dat;
      e.name = name;
      exp_q.push_back(e);
      adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      n = 0;
      @(posedge clk);
      #1;
      while (!(ack_o || err_o) && n < 4) begin
         n++;
         @(posedge clk);
         #1;
      end
      if (!(ack_o || err_o)) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no ack/err, required a response within 5 cycles", name);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_ack", {31'b0, ack_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_irq", irq_o, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc_n(1);

      // Level source, 3-cycle latency
      wb(1, 5'h08, 32'h4, 4'hF, 0, 0, "wr_mask4");
      cyc_n(1);
      irq_i[2] = 1'b1;
      cyc_n(2);
      chk("irq2_rise_at2", irq_o, 32'h0);
      cyc_n(1);
      chk("irq2_rise_at3", irq_o, 32'h4);
      wb(0, 5'h00, 0, 4'hF, 0, 32'h4, "rd_status");
      cyc_n(1);
      irq_i[2] = 1'b0;
      cyc_n(2);
      chk("irq2_fall_at2", irq_o, 32'h4);
      cyc_n(1);
      chk("irq2_fall_at3", irq_o, 32'h0);

      // Edge source, pulse then W1C
      wb(1, 5'h0C, 32'h400, 4'hF, 0, 0, "wr_mode400");
      cyc_n(1);
      wb(1, 5'h08, 32'h400, 4'hF, 0, 0, "wr_mask400");
      cyc_n(1);
      irq_i[10] = 1'b1;
      cyc_n(1);
      irq_i[10] = 1'b0;
      cyc_n(5);
      chk("irq10_edge_held", irq_o, 32'h400);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h400, "rd_pend_edge");
      cyc_n(1);
      wb(1, 5'h04, 32'h400, 4'hF, 0, 0, "w1c_400");
      chk("irq10_after_w1c", irq_o, 32'h0);
      cyc_n(1);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h0, "rd_pend_cleared");
      cyc_n(2);

      // W1C lands on the same edge as a new synchronised rise: set wins
      irq_i[10] = 1'b1;
      cyc_n(2);
      wb(1, 5'h04, 32'h400, 4'hF, 0, 0, "w1c_collide");
      chk("irq10_set_wins", irq_o, 32'h400);
      cyc_n(1);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h400, "rd_pend_collide");
      cyc_n(1);
      wb(1, 5'h04, 32'h400, 4'hF, 0, 0, "w1c_again");
      cyc_n(1);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h0, "rd_pend_w1c2");
      irq_i[10] = 1'b0;
      cyc_n(4);

      // Active-low source, then switch it to edge mode
      wb(1, 5'h10, 32'h800, 4'hF, 0, 0, "wr_pol800");
      cyc_n(2);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h800, "rd_pend_pol");
      cyc_n(1);
      wb(1, 5'h04, 32'h800, 4'hF, 0, 0, "w1c_level");
      cyc_n(1);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h800, "rd_pend_level_w1c");
      cyc_n(1);
      wb(1, 5'h0C, 32'hC00, 4'hF, 0, 0, "wr_modeC00");
      cyc_n(1);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h0, "rd_pend_modechg");
      irq_i[11] = 1'b1;
      cyc_n(5);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h0, "rd_pend_rise_ignored");
      irq_i[11] = 1'b0;
      cyc_n(5);
      wb(0, 5'h04, 0, 4'hF, 0, 32'h800, "rd_pend_fall_edge");
      cyc_n(1);

      // Unmapped accesses and byte enables
      wb(0, 5'h1C, 0, 4'hF, 1, 32'h0, "rd_unmapped1c");
      cyc_n(1);
      wb(1, 5'h08, 32'h0, 4'hF, 0, 0, "wr_mask0");
      cyc_n(1);
      wb(1, 5'h18, 32'hFFFF_FFFF, 4'hF, 1, 0, "wr_unmapped18");
      cyc_n(1);
      wb(1, 5'h08, 32'hFFFF_FFFF, 4'b0001, 0, 0, "wr_mask_sel0");
      cyc_n(1);
      wb(0, 5'h08, 0, 4'hF, 0, 32'h0000_00FF, "rd_mask_ff");
      cyc_n(1);

`ifdef WB_IRQ_CTRL_PRIO_EN
      wb(1, 5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_mask_all");
      cyc_n(1);
      wb(1, 5'h0C, 32'hC28, 4'hF, 0, 0, "wr_modeC28");
      cyc_n(1);
      irq_i[3] = 1'b1;
      irq_i[5] = 1'b1;
      cyc_n(1);
      irq_i[3] = 1'b0;
      irq_i[5] = 1'b0;
      cyc_n(5);
      wb(0, 5'h14, 0, 4'hF, 0, 32'h8000_0003, "rd_prio_3");
      cyc_n(1);
      wb(1, 5'h04, 32'h8, 4'hF, 0, 0, "w1c_bit3");
      cyc_n(1);
      wb(0, 5'h14, 0, 4'hF, 0, 32'h8000_0005, "rd_prio_5");
`else
      wb(0, 5'h14, 0, 4'hF, 1, 32'h0, "rd_prio_unmapped");
`endif

      cyc_n(3);
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Parametrised Wishbone B3 interrupt controller between peripheral interrupt lines (uart0, qsfp_i2c0/1, future blocks) and the 32-bit or1k_irq vector.
- Replaces hard-wired irq assignment with a per-source block: synchroniser, polarity select, edge/level mode, mask, and write-1-to-clear pending.
- Sits on the Wishbone intercon as a slave.
- Its irq_o vector drives or1k_irq directly.

Parameters:
- NUM_SRC, 32, number of interrupt sources (1..32); register bits [31:NUM_SRC] read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages on each irq_i bit (>=2).
- RESET_MASK, 32'h0, mask register reset value.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  5  byte address; [4:2] selects the register, [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables for writes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  accepted; every access is treated as classic.
- wb_bte_i  in  2  accepted, ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error, for an unmapped address.
- irq_i  in  NUM_SRC  asynchronous interrupt inputs.
- irq_o  out  NUM_SRC  pending & mask, to the CPU PIC.

Behaviour:
- Reset (async, wb_rst_ni=0): all synchroniser flops, PENDING, MODE and POLARITY are 0; MASK=RESET_MASK.
- Reset outputs: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
- Reset mid-transaction aborts the access; no ack is issued for it.
- Input path, per bit:
  - s = sync(irq_i) XOR POLARITY; s_d = s delayed one cycle.
  - Level mode (MODE=0): PENDING <= s every cycle; W1C has no effect.
  - Edge mode (MODE=1): PENDING <= (PENDING & ~clr) | (s & ~s_d).
  - If an edge and a W1C clear hit the same cycle, set wins.
- Latency: an irq_i change reaches irq_o SYNC_STAGES+1 cycles later (3 by default).
- irq_o = PENDING & MASK, built from register outputs only; no extra stage.
- Register map (word offsets):
  - 0x00 STATUS, RO: PENDING & MASK.
  - 0x04 PENDING, R/W1C: write 1 clears edge-mode bits.
  - 0x08 MASK, RW.
  - 0x0C MODE, RW: 1 = edge.
  - 0x10 POLARITY, RW: 1 = active-low input.
  - 0x14 PRIO, RO, optional feature only.
- Addresses 0x18..0x1C, and 0x14 when the feature is off, are unmapped.
- Writes honour wb_sel_i per byte.
- Writing MODE or POLARITY clears PENDING for every bit whose MODE or POLARITY changed.
  - This prevents a spurious edge on reconfiguration.
  - s_d is reloaded with the new s in the same cycle.
- Wishbone slave, two-state FSM IDLE/ACK:
  - IDLE: on cyc&stb, go to ACK. Raise wb_ack_o, or wb_err_o if unmapped, for exactly one cycle. Write side effects take effect at that same edge. wb_dat_o is registered in the same cycle.
  - ACK: return to IDLE unconditionally. ack/err drop to 0 and wb_dat_o holds its value.
  - Throughput: at most one access per 2 cycles; stb held high restarts from IDLE.
  - An unmapped write has no effect; an unmapped read returns 0 with err.
  - cyc dropping while in ACK has no effect on state.

Optional Feature:
- Macro: WB_IRQ_CTRL_PRIO_EN.
- Defined:
  - Register 0x14 PRIO reads {valid, 26'b0, idx[4:0]}.
  - idx = lowest-numbered bit set in PENDING & MASK; valid=1 when any bit is set.
  - PRIO is a combinational priority encode, registered only through the wb_dat_o read path.
  - Adds one 32-bit compare chain.
- Undefined: 0x14 is unmapped (err) and no encoder logic is generated.

Test Plan:
- Reset with MASK write 0x4 and irq_i[2] level high -> irq_o[2]=1 exactly 3 cycles after the input rises; STATUS read =0x00000004; input low -> irq_o[2]=0 3 cycles later.
- MODE=0x400, MASK=0x400, pulse irq_i[10] for one cycle -> PENDING=0x400 held after the pulse; write 0x400 to PENDING -> irq_o[10]=0 on the cycle after ack.
- Edge source with W1C of that bit in the same cycle as a new synchronised edge -> PENDING bit stays 1.
- POLARITY=0x800 with irq_i[11]=0 -> level pending 1; then set MODE bit 11 -> PENDING[11] cleared; next falling edge of irq_i[11] sets it.
- Read 0x1C -> wb_err_o=1 for one cycle, wb_ack_o=0, wb_dat_o=0; wb_sel_i=4'b0001 write of 0xFFFFFFFF to MASK -> MASK=0x000000FF.
- With WB_IRQ_CTRL_PRIO_EN: MASK=0xFFFFFFFF, sources 5 and 3 pending -> PRIO=0x80000003; clear bit 3 -> PRIO=0x80000005; without the macro, a read of 0x14 returns err.
